// File: rtl/gpu_fill_pkg.sv
// Shared state encoding for the polygon fill sequencer.
// Pure type/constant definitions; no logic.
package gpu_fill_pkg;

  localparam int FILL_SEQ_STATE_W = 4;

  typedef enum logic [FILL_SEQ_STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_MATH      = 4'd1,
    ST_MATH_WAIT = 4'd2,
    ST_ROW       = 4'd3,
    ST_ROW_WAIT  = 4'd4,
    ST_FILL      = 4'd5,
    ST_FILL_WAIT = 4'd6,
    ST_NEXT      = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERR       = 4'd9
  } fill_seq_state_t;

endpackage

// File: rtl/fill_row_counter.sv
// Scanline counter: loads y_start/y_end, steps one row toward y_end per step pulse.
// Registered outputs; last flags cur_y == y_end so the sequencer never steps past it.
module fill_row_counter #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] y_end,
  output logic [COORD_W-1:0] cur_y,
  output logic               last
);

  localparam logic [COORD_W-1:0] Y_ONE = COORD_W'(1);

  logic [COORD_W-1:0] cur_y_q, cur_y_d;
  logic [COORD_W-1:0] y_end_q, y_end_d;
  logic               up_q, up_d;

  always_comb begin
    cur_y_d = cur_y_q;
    y_end_d = y_end_q;
    up_d    = up_q;
    if (load) begin
      cur_y_d = y_start;
      y_end_d = y_end;
      up_d    = (y_end > y_start);
    end else if (step) begin
      cur_y_d = up_q ? (cur_y_q + Y_ONE) : (cur_y_q - Y_ONE);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur_y_q <= '0;
      y_end_q <= '0;
      up_q    <= 1'b0;
    end else begin
      cur_y_q <= cur_y_d;
      y_end_q <= y_end_d;
      up_q    <= up_d;
    end
  end

  assign cur_y = cur_y_q;
  assign last  = (cur_y_q == y_end_q);

endmodule

// File: rtl/fill_sequencer.sv
// Multi-scanline fill sequencer: one edge setup, then row fetch / span fill per scanline.
// Moore start/done outputs; waits on *_done handshakes, bounded only when FILL_SEQ_TIMEOUT_EN is defined.
module fill_sequencer
  import gpu_fill_pkg::*;
#(
  parameter int COORD_W = 10
`ifdef FILL_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_en,
  input  logic               abort,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] y_end,
  input  logic               math_done,
  input  logic               row_done,
  input  logic               row_empty,
  input  logic               fill_done,
  output logic               math_start,
  output logic               row_start,
  output logic               fill_start,
  output logic [COORD_W-1:0] cur_y,
  output logic [COORD_W:0]   rows_done,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [COORD_W:0] RD_ONE = (COORD_W+1)'(1);

  fill_seq_state_t  state_q, state_d;
  logic [COORD_W:0] rows_done_q, rows_done_d;
  logic             cnt_load, cnt_step, cnt_last;
  logic             tmo;

  fill_row_counter #(
    .COORD_W (COORD_W)
  ) u_row_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (cnt_load),
    .step    (cnt_step),
    .y_start (y_start),
    .y_end   (y_end),
    .cur_y   (cur_y),
    .last    (cnt_last)
  );

  // abort pre-empts everything, including a same-cycle *_done or timeout
  always_comb begin
    state_d     = state_q;
    rows_done_d = rows_done_q;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    if (abort) begin
      if (state_q != ST_IDLE) state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fill_en) begin
            cnt_load    = 1'b1;
            rows_done_d = '0;
            state_d     = ST_MATH;
          end
        end
        ST_MATH: begin
          if (math_done) state_d = ST_MATH_WAIT;
          else if (tmo)  state_d = ST_ERR;
        end
        ST_MATH_WAIT: state_d = ST_ROW;
        ST_ROW: begin
          if (row_done) state_d = row_empty ? ST_NEXT : ST_ROW_WAIT;
          else if (tmo) state_d = ST_ERR;
        end
        ST_ROW_WAIT: state_d = ST_FILL;
        ST_FILL: begin
          if (fill_done) state_d = ST_FILL_WAIT;
          else if (tmo)  state_d = ST_ERR;
        end
        ST_FILL_WAIT: state_d = ST_NEXT;
        ST_NEXT: begin
          rows_done_d = rows_done_q + RD_ONE;
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_step = 1'b1;
            state_d  = ST_ROW;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      rows_done_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_done_q <= rows_done_d;
    end
  end

`ifdef FILL_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            error_q, error_d;
  logic            handshake_st;

  assign handshake_st = (state_q == ST_MATH) || (state_q == ST_ROW) || (state_q == ST_FILL);
  assign tmo          = handshake_st && (wdog_q == WD_LAST);

  always_comb begin
    wdog_d  = '0;
    error_d = error_q;
    if (handshake_st && (state_d == state_q)) wdog_d = wdog_q + WD_ONE;
    if ((state_q == ST_IDLE) && (state_d == ST_MATH)) error_d = 1'b0;
    else if (state_d == ST_ERR)                       error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign tmo   = 1'b0;
  assign error = 1'b0;
`endif

  assign math_start = (state_q == ST_MATH);
  assign row_start  = (state_q == ST_ROW);
  assign fill_start = (state_q == ST_FILL);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rows_done  = rows_done_q;

endmodule
